// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (IF/DM) arbiter onto a single-port fixed-latency memory
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              halt,
    output logic              idle,
    output logic              stall
);

    if (MEM_LAT < 1) begin : g_bad_mem_lat
        $error("mem_arbiter: MEM_LAT must be at least 1");
    end

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               owner_dm_q, owner_dm_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               halt_pending_q, halt_pending_d;
    logic [1:0]         streak_q, streak_d;
    logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]  dm_rdata_q, dm_rdata_d;
    logic               if_ack_q, if_ack_d;
    logic               dm_ack_q, dm_ack_d;
    logic               mem_en_q, mem_en_d;
    logic               grant_ok;
    logic               dm_wins;

    // Grant decision: DM first unless IF has been starved by two DM wins in a row
    always_comb begin
        grant_ok = (state_q == S_IDLE) && !halt_pending_q && !halt && !rst;
        dm_wins  = dm_req && !((streak_q == 2'd2) && if_req);
        dm_gnt   = grant_ok && dm_wins;
        if_gnt   = grant_ok && if_req && !dm_wins;
    end

    // Next-state for the FSM, latched request, completion timing and read capture
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        owner_dm_d     = owner_dm_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        halt_pending_d = halt_pending_q | halt;
        streak_d       = streak_q;
        if_rdata_d     = if_rdata_q;
        dm_rdata_d     = dm_rdata_q;
        if_ack_d       = 1'b0;
        dm_ack_d       = 1'b0;
        mem_en_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (halt_pending_q || halt) begin
                    state_d = S_HALTED;
                end else if (dm_gnt || if_gnt) begin
                    state_d    = S_ACCESS;
                    cnt_d      = '0;
                    mem_en_d   = 1'b1;
                    owner_dm_d = dm_gnt;
                    we_d       = dm_gnt && dm_we;
                    addr_d     = dm_gnt ? dm_addr : if_addr;
                    wdata_d    = dm_gnt ? dm_wdata : '0;
                    if (if_gnt) begin
                        streak_d = 2'd0;
                    end else if (if_req && (streak_q != 2'd2)) begin
                        streak_d = streak_q + 2'd1;
                    end
                end
            end
            S_ACCESS: begin
                // cnt_q == 0 is the mem_en cycle; read data is valid MEM_LAT cycles later
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    if (owner_dm_q) begin
                        dm_ack_d = 1'b1;
                        if (!we_q) dm_rdata_d = mem_rdata;
                    end else begin
                        if_ack_d = 1'b1;
                        if (!we_q) if_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    // State register; reset aborts any access in flight without ack or capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            owner_dm_q     <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            halt_pending_q <= 1'b0;
            streak_q       <= 2'd0;
            if_rdata_q     <= '0;
            dm_rdata_q     <= '0;
            if_ack_q       <= 1'b0;
            dm_ack_q       <= 1'b0;
            mem_en_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            owner_dm_q     <= owner_dm_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            halt_pending_q <= halt_pending_d;
            streak_q       <= streak_d;
            if_rdata_q     <= if_rdata_d;
            dm_rdata_q     <= dm_rdata_d;
            if_ack_q       <= if_ack_d;
            dm_ack_q       <= dm_ack_d;
            mem_en_q       <= mem_en_d;
        end
    end

    // Memory bus is forced to zero outside the single enable cycle
    always_comb begin
        mem_en    = mem_en_q;
        mem_we    = mem_en_q ? we_q    : 1'b0;
        mem_addr  = mem_en_q ? addr_q  : '0;
        mem_wdata = mem_en_q ? wdata_q : '0;
        if_ack    = if_ack_q;
        dm_ack    = dm_ack_q;
        if_rdata  = if_rdata_q;
        dm_rdata  = dm_rdata_q;
        idle      = (state_q == S_HALTED);
        stall     = (state_q == S_ACCESS) || ((state_q == S_IDLE) && (if_req || dm_req));
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized check of mem_arbiter against a timeline model
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int L  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, halt = 1'b0;
    logic [AW-1:0] if_addr = '0, dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0, mem_rdata = '0;
    logic          if_gnt, if_ack, dm_gnt, dm_ack, mem_en, mem_we, idle, stall;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .halt(halt), .idle(idle), .stall(stall)
    );

    int total = 0;
    int bad   = 0;

    // Timeline model: one access at a time, booked as absolute cycle numbers
    int            t = 0;
    int            next_free = 0;
    bit            active = 0;
    int            acc_t = 0;
    bit            acc_dm = 0, acc_we = 0;
    logic [AW-1:0] acc_addr = '0;
    logic [DW-1:0] acc_wd = '0;
    logic [DW-1:0] m_if_rd = '0, m_dm_rd = '0;
    bit            hp = 0, halted = 0;
    int            streak = 0;
    bit            e_ifg = 0, e_dmg = 0, o_ifg = 0, o_dmg = 0;
    bit            in_idle, can_grant, en_now, ack_now;
    string         order;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at cycle %0d: got %0h want %0h", tag, t, obs, exp);
        end
    endtask

    task automatic model_reset();
        next_free = t; active = 0; m_if_rd = '0; m_dm_rd = '0;
        hp = 0; halted = 0; streak = 0;
    endtask

    // One clock cycle: inputs already applied; check mid-cycle, advance model past the edge
    task automatic cycle();
        bit rst_now;
        #3;
        rst_now   = rst;
        in_idle   = !halted && (t >= next_free);
        can_grant = in_idle && !hp && !halt && !rst;
        e_dmg     = can_grant && dm_req && !((streak == 2) && if_req);
        e_ifg     = can_grant && if_req && !e_dmg;
        en_now    = active && (t == acc_t + 1);
        ack_now   = active && (t == acc_t + L + 2);
        o_dmg     = dm_gnt;
        o_ifg     = if_gnt;
        chk("dm_gnt", dm_gnt, e_dmg);
        chk("if_gnt", if_gnt, e_ifg);
        if (!rst_now) begin
            chk("mem_en", mem_en, en_now);
            chk("mem_we", mem_we, en_now ? acc_we : 1'b0);
            chk("mem_addr", mem_addr, en_now ? acc_addr : '0);
            chk("mem_wdata", mem_wdata, en_now ? acc_wd : '0);
            chk("if_ack", if_ack, ack_now && !acc_dm);
            chk("dm_ack", dm_ack, ack_now && acc_dm);
            chk("if_rdata", if_rdata, m_if_rd);
            chk("dm_rdata", dm_rdata, m_dm_rd);
            chk("idle", idle, halted);
            chk("stall", stall, !halted && ((t < next_free) || if_req || dm_req));
        end
        @(posedge clk);
        #1;
        if (active && (t == acc_t + L + 1) && !acc_we) begin
            if (acc_dm) m_dm_rd = mem_rdata;
            else        m_if_rd = mem_rdata;
        end
        if (ack_now) active = 0;
        if (in_idle && (hp || halt)) halted = 1;
        if (halt) hp = 1;
        if (e_dmg || e_ifg) begin
            active    = 1;
            acc_t     = t;
            acc_dm    = e_dmg;
            acc_we    = e_dmg && dm_we;
            acc_addr  = e_dmg ? dm_addr : if_addr;
            acc_wd    = e_dmg ? dm_wdata : '0;
            next_free = t + L + 2;
            if (e_ifg) streak = 0;
            else if (if_req && streak < 2) streak++;
        end
        t++;
        if (rst_now) model_reset();
    endtask

    initial begin
        @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;
        cycle();

        // Single IF read
        if_req = 1'b1; if_addr = 16'h0010; mem_rdata = 32'hDEADBEEF;
        cycle();
        if_req = 1'b0;
        repeat (5) cycle();
        chk("single_if_rdata", if_rdata, 32'hDEADBEEF);

        // Contention: DM write first, IF follows in the DM ack cycle
        if_req = 1'b1; if_addr = 16'h0044;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0020; dm_wdata = 32'h55;
        cycle();
        dm_req = 1'b0; dm_we = 1'b0;
        repeat (3) cycle();
        cycle();
        if_req = 1'b0;
        repeat (5) cycle();
        chk("contention_dm_rdata", dm_rdata, 32'h0);

        // Fairness with both requesters held
        order = "";
        if_req = 1'b1; dm_req = 1'b1;
        repeat (24) begin
            cycle();
            if (o_dmg) order = {order, "D"};
            if (o_ifg) order = {order, "I"};
        end
        total++;
        assert (order == "DDIDDI") else begin
            bad++;
            $error("FAIL fairness_order: got %s want DDIDDI", order);
        end
        if_req = 1'b0; dm_req = 1'b0;
        repeat (4) cycle();

        // Halt during an IF access, requests pending at its ack
        if_req = 1'b1; if_addr = 16'h0100;
        cycle();
        if_req = 1'b0;
        cycle();
        halt = 1'b1;
        cycle();
        halt = 1'b0; if_req = 1'b1; dm_req = 1'b1;
        repeat (6) cycle();
        chk("halt_idle", idle, 1'b1);
        if_req = 1'b0; dm_req = 1'b0;

        // Reset during a DM read, then an IF request right after
        rst = 1'b1; cycle(); rst = 1'b0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0200;
        cycle();
        dm_req = 1'b0;
        cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        cycle();
        if_req = 1'b1; if_addr = 16'h0300;
        cycle();
        if_req = 1'b0;
        repeat (6) cycle();

        // Randomized traffic with requesters that hold until granted
        for (int i = 0; i < 3000; i++) begin
            if (!if_req || e_ifg) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = AW'($urandom);
            end
            if (!dm_req || e_dmg) begin
                dm_req   = ($urandom_range(0, 2) != 0);
                dm_we    = $urandom_range(0, 1) == 1;
                dm_addr  = AW'($urandom);
                dm_wdata = $urandom;
            end
            mem_rdata = $urandom;
            halt      = ($urandom_range(0, 149) == 0);
            rst       = halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 249) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
